mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 117 +++++++++++
 tb/tb_mem_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with fixed latency.
// A request accepted in IDLE is captured and counted down in WAIT. On the
// commit edge a store writes the word array or a load reads it. The response
// is then held in RESP until the initiator takes it.
// Ports:
//   clk        - clock; all state updates on the rising edge
//   rst        - asynchronous, active-low reset
//   req_valid  - request present        req_ready - responder can accept
//   req_write  - 1 = store, 0 = load    req_addr  - byte address
//   req_wdata  - store data
//   rsp_valid  - response present       rsp_ready - initiator takes response
//   rsp_rdata  - load data (0 for stores/errors)
//   rsp_err    - misaligned or out-of-range request
module mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned WORDS    = 1 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, state_nx;
  logic [3:0]              cnt;
  logic                    cap_write;
  logic [31:0]             cap_addr;
  logic [31:0]             cap_wdata;
  logic [31:0]             mem [WORDS];
  logic                    accept;
  logic                    commit;
  logic                    addr_err;
  logic [DEPTH_LOG2-1:0]   index;

  // Error covers misalignment and any address bit above the word array.
  assign addr_err = (cap_addr[1:0] != 2'b00) ||
                    ((cap_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign index    = cap_addr[DEPTH_LOG2+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          commit   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cnt       <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rsp_rdata <= (!addr_err && !cap_write) ? mem[index] : '0;
        rsp_err   <= addr_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (commit && cap_write && !addr_err) begin
      mem[index] <= cap_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: scoreboard of expected responses, checked by
// a monitor on each response handshake; a second LATENCY=1 instance covers
// back-to-back timing.
module tb_mem_responder;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready;
  logic [31:0] b_rsp_rdata;
  logic        b_rsp_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [32:0] sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.DEPTH_LOG2(6), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mem_responder #(.DEPTH_LOG2(6), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: one pop per response handshake.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", {31'd0, rsp_err, rsp_rdata}, 64'h1_0000_0000_0000);
      end else begin
        check("rsp", {31'd0, rsp_err, rsp_rdata}, {31'd0, sb_q.pop_front()});
      end
    end
  end

  // Returns #1 after the accepting edge.
  task automatic wait_accept();
    int k = 0;
    #1;
    while (!req_ready && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) check("accept_timeout", req_ready, 1);
    @(posedge clk); #1;
  endtask

  // Counts edges from accept until rsp_valid; returns #1 after that edge.
  task automatic wait_rsp(input string nm);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rsp_valid && n < 20);
    check(nm, n, LAT);
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e);
    sb_q.push_back({exp_e, exp_d});
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    wait_accept();
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0;
    wait_rsp("latency");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b_exp [3];
    int prev_acc, acc, k;

    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    b_rsp_ready = 1'b1;

    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    @(negedge clk); rst = 1'b1;

    // Basic load, store, read-after-write.
    do_req(1'b0, 32'h8, 32'h0, 32'h0, 1'b0);
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Error cases; the out-of-range store must not alias onto any word.
    do_req(1'b0, 32'h6, 32'h0, 32'h0, 1'b1);
    do_req(1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
    do_req(1'b1, 32'h100, 32'hCAFEF00D, 32'h0, 1'b1);
    do_req(1'b1, 32'h3, 32'h5A5A5A5A, 32'h0, 1'b1);
    for (int i = 0; i < 64; i++)
      do_req(1'b0, 32'(i * 4), 32'h0, (i == 4) ? 32'hDEADBEEF : 32'h0, 1'b0);

    // Backpressure with a second request held throughout.
    sb_q.push_back({1'b0, 32'hDEADBEEF});
    rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    wait_accept();
    req_addr = 32'h8;
    check("wait_req_ready", req_ready, 0);
    wait_rsp("bp_latency");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp_rsp_err", rsp_err, 0);
      check("bp_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    sb_q.push_back({1'b0, 32'h0});
    @(posedge clk); #1;
    check("post_hs_req_ready", req_ready, 1);
    check("post_hs_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    check("second_accepted", req_ready, 0);
    req_valid = 1'b0; req_addr = '0;
    wait_rsp("bp2_latency");
    @(posedge clk); #1;

    // Reset during WAIT discards the store.
    do_req(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'h12345678; req_valid = 1'b1;
    wait_accept();
    req_valid = 1'b0; req_write = 1'b0; req_wdata = '0;
    #2 rst = 1'b0;
    #1;
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_req_ready", req_ready, 1);
    check("arst_rsp_rdata", rsp_rdata, 0);
    check("arst_rsp_err", rsp_err, 0);
    @(negedge clk);
    rst = 1'b1;
    sb_q.push_back({1'b0, 32'h0});
    req_write = 1'b0; req_addr = 32'h4; req_valid = 1'b1;
    @(posedge clk); #1;
    check("first_edge_accept", req_ready, 0);
    req_valid = 1'b0; req_addr = '0;
    wait_rsp("post_rst_latency");
    @(posedge clk); #1;
    do_req(1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

    // LATENCY=1 instance: back-to-back transactions with req_valid held.
    b_exp[0] = 32'h0; b_exp[1] = 32'hA5A50001; b_exp[2] = 32'h0;
    b_req_write = 1'b1; b_req_addr = 32'h8; b_req_wdata = 32'hA5A50001;
    b_req_valid = 1'b1;
    prev_acc = 0;
    for (int t = 0; t < 3; t++) begin
      k = 0;
      #1;
      while (!b_req_ready && k < 10) begin
        @(posedge clk); #1;
        k++;
      end
      check("l1_ready", b_req_ready, 1);
      @(posedge clk);
      #1;
      acc = cyc;
      check("l1_not_early", b_rsp_valid, 0);
      if (t == 0) begin
        b_req_write = 1'b0; b_req_wdata = '0;
      end else begin
        b_req_addr = 32'hC;
      end
      @(posedge clk); #1;
      check("l1_rsp_valid", b_rsp_valid, 1);
      check("l1_rsp_rdata", b_rsp_rdata, b_exp[t]);
      check("l1_rsp_err", b_rsp_err, 0);
      if (t > 0) check("l1_spacing", acc - prev_acc, 3);
      prev_acc = acc;
      @(posedge clk);
    end
    b_req_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
